pc_ret_stack: RTL and testbench

- Hardware return-address stack for the RAT CPU program counter.
- CALL or interrupt entry pushes the return PC. RET/RETIE pops it.
- TOP drives the program-counter mux "from stack" input.
- TOP is valid combinationally-from-registers before the pop edge, so the PC loads the return address on the same edge that pops it.

---
 rtl/pc_ret_stack.sv | 133 +++++++++++++
 tb/tb_pc_ret_stack.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ret_stack.sv
// Return-address stack feeding the RAT CPU program-counter "from stack" mux input.
// Latency: TOP comes straight from a register, so it is valid before the pop edge. All updates take effect on the next rising CLK.
// Backpressure: none. A push while full is dropped and sets OVERFLOW. A pop while empty is ignored and sets UNDERFLOW. Both flags are sticky.
//
// Ports:
//   CLK, RST            clock; asynchronous active-high reset
//   PUSH, POP           CALL/interrupt entry push, RET/RETIE pop (PUSH+POP = replace top)
//   CLR_ERR             synchronous clear of OVERFLOW/UNDERFLOW (a new error in the same cycle wins)
//   PUSH_DATA [9:0]     return address to store
//   TOP [9:0]           current top-of-stack, 10'h000 when empty
//   COUNT [PTR_W:0]     number of valid entries, 0..DEPTH
//   EMPTY, FULL         decoded from COUNT
//   OVERFLOW, UNDERFLOW sticky error flags
module pc_ret_stack #(
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PUSH,
    input  logic             POP,
    input  logic             CLR_ERR,
    input  logic [9:0]       PUSH_DATA,
    output logic [9:0]       TOP,
    output logic [PTR_W:0]   COUNT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam int CW = PTR_W + 1;

    // Entry storage. It has no reset; only COUNT defines which entries are valid.
    logic [9:0]       mem [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [9:0]       top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [9:0]       mem_wdata;

    logic             empty;
    logic             full;
    logic             ovf_set;
    logic             unf_set;

    // Pointer arithmetic uses only the low PTR_W bits. When COUNT==DEPTH these
    // bits are all zero, so subtracting one wraps to DEPTH-1, which is the
    // correct top index. The COUNT MSB only matters for the FULL decode.
    logic [PTR_W-1:0] ptr_wr;     // next free slot  (COUNT)
    logic [PTR_W-1:0] ptr_m1;     // current top      (COUNT-1)
    logic [PTR_W-1:0] ptr_m2;     // entry under top  (COUNT-2)

    assign ptr_wr = count_q[PTR_W-1:0];
    assign ptr_m1 = count_q[PTR_W-1:0] - PTR_W'(1);
    assign ptr_m2 = count_q[PTR_W-1:0] - PTR_W'(2);

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));

    always_comb begin
        count_d   = count_q;
        top_d     = top_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_wr;
        mem_wdata = PUSH_DATA;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        if (PUSH && POP && !empty) begin
            // Return-and-call in the same cycle: overwrite the top in place.
            mem_we    = 1'b1;
            mem_waddr = ptr_m1;
            top_d     = PUSH_DATA;
        end else if (PUSH && POP) begin
            // Nothing to pop. The push still goes through, but the pop is an error.
            mem_we    = 1'b1;
            mem_waddr = '0;
            top_d     = PUSH_DATA;
            count_d   = CW'(1);
            unf_set   = 1'b1;
        end else if (PUSH && !full) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_wr;
            top_d     = PUSH_DATA;
            count_d   = count_q + CW'(1);
        end else if (PUSH) begin
            ovf_set   = 1'b1;
        end else if (POP && !empty) begin
            count_d   = count_q - CW'(1);
            // Refill the top cache from the entry that becomes the new top.
            top_d     = (count_q >= CW'(2)) ? mem[ptr_m2] : 10'h000;
        end else if (POP) begin
            unf_set   = 1'b1;
        end

        // The clear is applied first, so a new error in the same cycle still sets the flag.
        ovf_d = (ovf_q & ~CLR_ERR) | ovf_set;
        unf_d = (unf_q & ~CLR_ERR) | unf_set;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            top_q   <= 10'h000;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign TOP       = top_q;
    assign COUNT     = count_q;
    assign EMPTY     = empty;
    assign FULL      = full;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_pc_ret_stack.sv
module tb_pc_ret_stack;

    localparam int DEPTH = 32;
    localparam int PTR_W = 5;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           PUSH = 1'b0;
    logic           POP = 1'b0;
    logic           CLR_ERR = 1'b0;
    logic [9:0]     PUSH_DATA = '0;
    logic [9:0]     TOP;
    logic [PTR_W:0] COUNT;
    logic           EMPTY, FULL, OVERFLOW, UNDERFLOW;

    pc_ret_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .CLR_ERR(CLR_ERR),
        .PUSH_DATA(PUSH_DATA), .TOP(TOP), .COUNT(COUNT), .EMPTY(EMPTY),
        .FULL(FULL), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue whose back is the top of the stack.
    int m_q[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    function automatic int m_top();
        return (m_q.size() > 0) ? m_q[$] : 0;
    endfunction

    function automatic void model_step(bit push, bit pop, bit clr, int data);
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (push && pop) begin
            if (m_q.size() > 0) m_q[m_q.size()-1] = data;
            else begin m_q.push_back(data); m_unf = 1; end
        end else if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(data);
            else m_ovf = 1;
        end else if (pop) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_unf = 1;
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_ovf = 0;
        m_unf = 0;
    endfunction

    task automatic chk_top(string name, int exp);
        checks++;
        if (int'(TOP) != exp) begin
            errors++;
            $display("FAIL %s: TOP got %03h expected %03h", name, TOP, exp[9:0]);
        end
    endtask

    task automatic chk_state(string name, int e_top, int e_cnt, bit e_ovf, bit e_unf);
        bit e_empty, e_full;
        e_empty = (e_cnt == 0);
        e_full  = (e_cnt == DEPTH);
        checks++;
        if (int'(TOP) != e_top || int'(COUNT) != e_cnt || EMPTY != e_empty ||
            FULL != e_full || OVERFLOW != e_ovf || UNDERFLOW != e_unf) begin
            errors++;
            $display("FAIL %s: got top=%03h cnt=%0d e=%0b f=%0b ovf=%0b unf=%0b expected top=%03h cnt=%0d e=%0b f=%0b ovf=%0b unf=%0b",
                     name, TOP, COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW,
                     e_top[9:0], e_cnt, e_empty, e_full, e_ovf, e_unf);
        end
    endtask

    task automatic chk_model(string name);
        chk_state(name, m_top(), m_q.size(), m_ovf, m_unf);
    endtask

    // Called at posedge+1. Drives one cycle of inputs and returns at the next posedge+1.
    task automatic cycle(bit push, bit pop, bit clr, int data);
        PUSH = push; POP = pop; CLR_ERR = clr; PUSH_DATA = data[9:0];
        @(posedge CLK);
        model_step(push, pop, clr, data);
        #1;
    endtask

    task automatic idle_inputs();
        PUSH = 0; POP = 0; CLR_ERR = 0; PUSH_DATA = '0;
    endtask

    // Asynchronous reset pulse placed between clock edges. Ends at posedge+1.
    task automatic do_reset(string name);
        idle_inputs();
        @(negedge CLK);
        RST = 1;
        #2;
        model_reset();
        chk_state(name, 0, 0, 0, 0);
        RST = 0;
        @(posedge CLK);
        #1;
    endtask

    typedef struct packed {
        bit       push;
        bit       pop;
        bit       clr;
        bit [9:0] data;
        bit [9:0] pre_top;
        bit [9:0] post_top;
        bit [6:0] post_cnt;
        bit       post_ovf;
        bit       post_unf;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    initial begin
        //            push pop clr data    pre     post    cnt ovf unf
        vecs[0]  = '{1, 0, 0, 10'h010, 10'h000, 10'h010, 1, 0, 0};
        vecs[1]  = '{1, 0, 0, 10'h020, 10'h010, 10'h020, 2, 0, 0};
        vecs[2]  = '{1, 0, 0, 10'h3FF, 10'h020, 10'h3FF, 3, 0, 0};
        vecs[3]  = '{0, 1, 0, 10'h000, 10'h3FF, 10'h020, 2, 0, 0};
        vecs[4]  = '{0, 1, 0, 10'h000, 10'h020, 10'h010, 1, 0, 0};
        vecs[5]  = '{0, 1, 0, 10'h000, 10'h010, 10'h000, 0, 0, 0};
        vecs[6]  = '{0, 1, 0, 10'h000, 10'h000, 10'h000, 0, 0, 1};
        vecs[7]  = '{0, 0, 1, 10'h000, 10'h000, 10'h000, 0, 0, 0};
        vecs[8]  = '{0, 1, 1, 10'h000, 10'h000, 10'h000, 0, 0, 1};
        vecs[9]  = '{0, 0, 1, 10'h000, 10'h000, 10'h000, 0, 0, 0};
        vecs[10] = '{1, 0, 0, 10'h100, 10'h000, 10'h100, 1, 0, 0};
        vecs[11] = '{1, 0, 0, 10'h200, 10'h100, 10'h200, 2, 0, 0};
        vecs[12] = '{1, 1, 0, 10'h2AA, 10'h200, 10'h2AA, 2, 0, 0};
        vecs[13] = '{0, 1, 0, 10'h000, 10'h2AA, 10'h100, 1, 0, 0};
        vecs[14] = '{0, 1, 0, 10'h000, 10'h100, 10'h000, 0, 0, 0};
        vecs[15] = '{1, 1, 0, 10'h0F0, 10'h000, 10'h0F0, 1, 0, 1};
        vecs[16] = '{0, 1, 1, 10'h000, 10'h0F0, 10'h000, 0, 0, 0};
        vecs[17] = '{1, 0, 0, 10'h000, 10'h000, 10'h000, 1, 0, 0};
        vecs[18] = '{1, 0, 0, 10'h3FF, 10'h000, 10'h3FF, 2, 0, 0};
        vecs[19] = '{0, 1, 0, 10'h000, 10'h3FF, 10'h000, 1, 0, 0};
        vecs[20] = '{0, 1, 0, 10'h000, 10'h000, 10'h000, 0, 0, 0};

        // The reset is asserted from time 0 and checked before any clock edge.
        #1;
        chk_state("reset_initial", 0, 0, 0, 0);
        @(posedge CLK); #1;
        RST = 0;
        @(posedge CLK); #1;
        chk_state("idle_after_reset", 0, 0, 0, 0);
        do_reset("reset_midcycle");

        // Directed table: TOP while the inputs are applied (zero-latency read), then the full state after the edge.
        for (int i = 0; i < NV; i++) begin
            PUSH = vecs[i].push; POP = vecs[i].pop; CLR_ERR = vecs[i].clr;
            PUSH_DATA = vecs[i].data;
            #1;
            chk_top($sformatf("vec%0d_pre", i), int'(vecs[i].pre_top));
            @(posedge CLK);
            model_step(vecs[i].push, vecs[i].pop, vecs[i].clr, int'(vecs[i].data));
            #1;
            chk_state($sformatf("vec%0d_post", i), int'(vecs[i].post_top),
                      int'(vecs[i].post_cnt), vecs[i].post_ovf, vecs[i].post_unf);
        end
        idle_inputs();

        // Fill to full, then overflow.
        do_reset("reset_before_full");
        for (int i = 1; i <= DEPTH; i++) cycle(1, 0, 0, i);
        idle_inputs();
        chk_state("full", 10'h020, DEPTH, 0, 0);
        cycle(1, 0, 0, 10'h155);
        idle_inputs();
        chk_state("overflow", 10'h020, DEPTH, 1, 0);
        POP = 1;
        #1;
        chk_top("pop_from_full_pre", 10'h020);
        cycle(0, 1, 0, 0);
        idle_inputs();
        chk_state("pop_from_full", 10'h01F, DEPTH - 1, 1, 0);
        cycle(1, 0, 0, 10'h2C3);
        cycle(1, 1, 0, 10'h0AB);   // replacing the top while full must not overflow further
        idle_inputs();
        chk_state("replace_at_full", 10'h0AB, DEPTH, 1, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0);
        idle_inputs();
        chk_state("drain_full", 10'h000, 0, 1, 0);

        // Reset coincident with a push edge at COUNT=5.
        do_reset("reset_before_midop");
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 10'h040 + i);
        chk_state("five_entries", 10'h044, 5, 0, 0);
        PUSH = 1; PUSH_DATA = 10'h077;
        @(posedge CLK);
        RST = 1;
        #1;
        model_reset();
        chk_state("reset_on_push_edge", 0, 0, 0, 0);
        idle_inputs();
        @(negedge CLK);
        RST = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk_state("push_not_recorded", 0, 0, 0, 0);

        // Random traffic against the model. The push/pop bias changes per phase so the stack reaches both full and empty.
        for (int ph = 0; ph < 12; ph++) begin
            int push_pct;
            push_pct = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
            for (int n = 0; n < 200; n++) begin
                int r;
                bit p, q, c;
                r = $urandom_range(0, 999);
                if (r < 3) begin
                    do_reset("rand_reset");
                end else begin
                    p = ($urandom_range(0, 99) < push_pct);
                    q = ($urandom_range(0, 99) < (100 - push_pct));
                    c = ($urandom_range(0, 99) < 5);
                    PUSH = p; POP = q; CLR_ERR = c;
                    PUSH_DATA = 10'($urandom_range(0, 1023));
                    #1;
                    if (q) chk_top("rand_pre_pop", m_top());
                    @(posedge CLK);
                    model_step(p, q, c, int'(PUSH_DATA));
                    #1;
                    chk_model("rand_post");
                end
            end
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the sequencing ever stalls.
    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
